// File: rtl/aib_pad_txrx_ctrl_pkg.sv
// Shared types for the AIB pad slice: the six driver enables bundled as one
// struct, plus a helper that steers a strong pull pair onto one generation.
package aib_pad_pkg;

   typedef struct packed {
      logic pu_gen1;
      logic pd_gen1;
      logic pu_gen2;
      logic pd_gen2;
      logic wkpu;
      logic wkpd;
   } pad_drv_t;

   localparam pad_drv_t PAD_DRV_OFF = '0;

   // Only the selected generation's pair is ever driven, so the pairs cannot overlap.
   function automatic pad_drv_t route_strong(input logic gen1, input logic pu, input logic pd);
      pad_drv_t r;
      r = PAD_DRV_OFF;
      if (gen1) begin
         r.pu_gen1 = pu;
         r.pd_gen1 = pd;
      end else begin
         r.pu_gen2 = pu;
         r.pd_gen2 = pd;
      end
      return r;
   endfunction

endpackage

// File: rtl/aib_pad_txrx_ctrl_if.sv
// Signal bundle between the adapter datapath / analog macro and the pad slice.
// There is no handshake: every signal is a level, valid on every cycle.
interface aib_pad_txrx_ctrl_if;

   logic tx_data;
   logic tx_en;
   logic tx_async;
   logic tx_async_en;
   logic gen1mode_en;
   logic tx_compen_p;
   logic tx_compen_n;
   logic pwrgood;
   logic pwrgood_io;
   logic rst_padlow_strap;
   logic wkpu_en;
   logic wkpd_en;
   logic rx_en;
   logic rx_async_en;
   logic pad_in;

   logic pu_gen1;
   logic pd_gen1;
   logic pu_gen2;
   logic pd_gen2;
   logic wkpu;
   logic wkpd;
   logic pad_oe;
   logic pad_strong;
   logic pad_out;
   logic pad_contention;
   logic rx_out;
   logic rx_async;

   modport master (
      output tx_data, tx_en, tx_async, tx_async_en, gen1mode_en,
      output tx_compen_p, tx_compen_n, pwrgood, pwrgood_io, rst_padlow_strap,
      output wkpu_en, wkpd_en, rx_en, rx_async_en, pad_in,
      input  pu_gen1, pd_gen1, pu_gen2, pd_gen2, wkpu, wkpd,
      input  pad_oe, pad_strong, pad_out, pad_contention, rx_out, rx_async
   );

   modport slave (
      input  tx_data, tx_en, tx_async, tx_async_en, gen1mode_en,
      input  tx_compen_p, tx_compen_n, pwrgood, pwrgood_io, rst_padlow_strap,
      input  wkpu_en, wkpd_en, rx_en, rx_async_en, pad_in,
      output pu_gen1, pd_gen1, pu_gen2, pd_gen2, wkpu, wkpd,
      output pad_oe, pad_strong, pad_out, pad_contention, rx_out, rx_async
   );

endinterface

// File: rtl/aib_pad_txrx_ctrl_sample_ff.sv
// Single-bit sample flop: async active-low reset, and a low enable reloads
// RST_VAL instead of holding, so a disabled path always reads back idle.
module txrx_sample_ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RST_VAL;
      end else begin
         q <= en ? d : RST_VAL;
      end
   end

endmodule

// File: rtl/aib_pad_txrx_ctrl.sv
// Digital core of one AIB pad slice: TX/RX sample flops, gated driver
// enable generation and resolution of those enables into a pad value.
module aib_pad_txrx_ctrl
   import aib_pad_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input logic                  clk,
   input logic                  rst,
   aib_pad_txrx_ctrl_if.slave   bus
);

   logic     tx_q;
   logic     rx_q;
   logic     d_sel;
   logic     pwr_ok;
   logic     spu;
   logic     spd;
   pad_drv_t drv;

   txrx_sample_ff #(.RST_VAL(RST_VAL)) u_tx_ff (
      .clk (clk),
      .rst (rst),
      .en  (bus.tx_en),
      .d   (bus.tx_data),
      .q   (tx_q)
   );

   txrx_sample_ff #(.RST_VAL(RST_VAL)) u_rx_ff (
      .clk (clk),
      .rst (rst),
      .en  (bus.rx_en),
      .d   (bus.pad_in),
      .q   (rx_q)
   );

   // The async path bypasses the flop entirely, giving zero-cycle latency.
   assign d_sel  = bus.tx_async_en ? bus.tx_async : tx_q;
   assign pwr_ok = bus.pwrgood & bus.pwrgood_io;

   always_comb begin
      drv = PAD_DRV_OFF;
      if (!pwr_ok) begin
         drv = PAD_DRV_OFF;
      end else if (bus.rst_padlow_strap) begin
         // Strap holds the pad low regardless of the pull-down calibration mask.
         drv = route_strong(bus.gen1mode_en, 1'b0, 1'b1);
      end else if (bus.tx_en || bus.tx_async_en) begin
         drv = route_strong(bus.gen1mode_en,
                            d_sel & bus.tx_compen_p,
                            ~d_sel & bus.tx_compen_n);
      end else begin
         drv.wkpu = bus.wkpu_en & ~bus.wkpd_en;
         drv.wkpd = bus.wkpd_en & ~bus.wkpu_en;
      end
   end

   assign bus.pu_gen1 = drv.pu_gen1;
   assign bus.pd_gen1 = drv.pd_gen1;
   assign bus.pu_gen2 = drv.pu_gen2;
   assign bus.pd_gen2 = drv.pd_gen2;
   assign bus.wkpu    = drv.wkpu;
   assign bus.wkpd    = drv.wkpd;

   assign spu = drv.pu_gen1 | drv.pu_gen2;
   assign spd = drv.pd_gen1 | drv.pd_gen2;

   assign bus.pad_strong     = spu | spd;
   assign bus.pad_oe         = spu | spd | drv.wkpu | drv.wkpd;
   assign bus.pad_out        = spu ? 1'b1 : (spd ? 1'b0 : drv.wkpu);
   assign bus.pad_contention = spu & spd;

   assign bus.rx_out   = rx_q;
   assign bus.rx_async = bus.rx_async_en & bus.pad_in;

endmodule

// File: tb/tb_aib_pad_txrx_ctrl.sv
// Directed bench for aib_pad_txrx_ctrl: a rule-level model of the pad slice
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_aib_pad_txrx_ctrl;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;
   logic m_tx_q;
   logic m_rx_q;

   aib_pad_txrx_ctrl_if bus ();

   aib_pad_txrx_ctrl #(.RST_VAL(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Model of the two sample flops, stated as "what was on the input at the last edge".
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_tx_q <= 1'b0;
         m_rx_q <= 1'b0;
      end else begin
         m_tx_q <= bus.tx_en ? bus.tx_data : 1'b0;
         m_rx_q <= bus.rx_en ? bus.pad_in  : 1'b0;
      end
   end

   // {pu1,pd1,pu2,pd2,wkpu,wkpd,oe,strong,out,contention,rx_out,rx_async}
   function automatic logic [11:0] act_vec();
      return {bus.pu_gen1, bus.pd_gen1, bus.pu_gen2, bus.pd_gen2, bus.wkpu, bus.wkpd,
              bus.pad_oe, bus.pad_strong, bus.pad_out, bus.pad_contention,
              bus.rx_out, bus.rx_async};
   endfunction

   function automatic logic [11:0] exp_vec();
      logic d, pu, pd, wu, wd, g1, lvl;
      d  = bus.tx_async_en ? bus.tx_async : m_tx_q;
      pu = 0; pd = 0; wu = 0; wd = 0;
      g1 = bus.gen1mode_en;
      if (bus.pwrgood && bus.pwrgood_io) begin
         if (bus.rst_padlow_strap) pd = 1;
         else if (bus.tx_en || bus.tx_async_en) begin
            pu = d && bus.tx_compen_p;
            pd = !d && bus.tx_compen_n;
         end else begin
            wu = bus.wkpu_en && !bus.wkpd_en;
            wd = bus.wkpd_en && !bus.wkpu_en;
         end
      end
      lvl = pu ? 1'b1 : (pd ? 1'b0 : wu);
      return {g1 & pu, g1 & pd, !g1 & pu, !g1 & pd, wu, wd,
              pu | pd | wu | wd, pu | pd, lvl, 1'b0,
              m_rx_q, bus.rx_async_en & bus.pad_in};
   endfunction

   // compare process: every cycle, mid-phase, after inputs have settled
   always @(negedge clk) chk("cycle", act_vec(), exp_vec());

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // {pu1,pd1,pu2,pd2,out,oe}
   function automatic logic [5:0] drv_vec();
      return {bus.pu_gen1, bus.pd_gen1, bus.pu_gen2, bus.pd_gen2, bus.pad_out, bus.pad_oe};
   endfunction

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b0;
      bus.tx_data = 0; bus.tx_en = 0; bus.tx_async = 0; bus.tx_async_en = 0;
      bus.gen1mode_en = 0; bus.tx_compen_p = 0; bus.tx_compen_n = 0;
      bus.pwrgood = 0; bus.pwrgood_io = 0; bus.rst_padlow_strap = 0;
      bus.wkpu_en = 0; bus.wkpd_en = 0; bus.rx_en = 0; bus.rx_async_en = 0;
      bus.pad_in = 0;
      step();
      step();
      chk("reset_state", act_vec(), 12'b0);
      rst = 1'b1;
      step();

      // gen1 synchronous transmit
      bus.pwrgood = 1; bus.pwrgood_io = 1; bus.tx_en = 1; bus.gen1mode_en = 1;
      bus.tx_compen_p = 1; bus.tx_compen_n = 1; bus.tx_data = 1;
      #1 chk("post_rst_pd", {6'b0, drv_vec()}, {6'b0, 6'b010001});
      step();
      chk("gen1_pu", {6'b0, drv_vec()}, {6'b0, 6'b100011});
      bus.tx_data = 0;
      step();
      chk("gen1_pd", {6'b0, drv_vec()}, {6'b0, 6'b010001});

      // gen2 async transmit, no edge between changes
      bus.gen1mode_en = 0; bus.tx_async_en = 1; bus.tx_async = 0;
      #1 chk("gen2_async0", {6'b0, drv_vec()}, {6'b0, 6'b000101});
      bus.tx_async = 1;
      #1 chk("gen2_async1", {6'b0, drv_vec()}, {6'b0, 6'b001011});
      step();

      // pad-low strap with d=1, then power loss overrides it
      bus.rst_padlow_strap = 1;
      #1 chk("strap_low", {6'b0, drv_vec()}, {6'b0, 6'b000101});
      bus.pwrgood = 0;
      #1 chk("pwr_off", act_vec(), 12'b0);
      step();

      // weak pulls
      bus.pwrgood = 1; bus.rst_padlow_strap = 0; bus.tx_en = 0; bus.tx_async_en = 0;
      bus.wkpu_en = 1;
      step();
      chk("weak_pu", {8'b0, bus.wkpu, bus.pad_strong, bus.pad_out, bus.pad_oe}, 12'b1011);
      bus.wkpd_en = 1;
      #1 chk("weak_both", {9'b0, bus.wkpu, bus.wkpd, bus.pad_oe}, 12'b0);
      bus.wkpu_en = 0; bus.wkpd_en = 0;
      step();

      // receive path
      bus.rx_en = 1; bus.pad_in = 1;
      step();
      chk("rx_1", {11'b0, bus.rx_out}, 12'd1);
      bus.pad_in = 0;
      step();
      chk("rx_0", {11'b0, bus.rx_out}, 12'd0);
      bus.pad_in = 1;
      step();
      chk("rx_1b", {11'b0, bus.rx_out}, 12'd1);
      bus.rx_async_en = 1; bus.pad_in = 0;
      #1 chk("rx_async0", {11'b0, bus.rx_async}, 12'd0);
      bus.pad_in = 1;
      #1 chk("rx_async1", {11'b0, bus.rx_async}, 12'd1);
      bus.rx_en = 0;
      step();
      chk("rx_disabled", {11'b0, bus.rx_out}, 12'd0);

      // async reset mid-stream
      bus.rx_en = 1; bus.rx_async_en = 0; bus.tx_en = 1; bus.gen1mode_en = 1; bus.tx_data = 1;
      step();
      chk("pre_rst", {bus.rx_out, 5'b0, drv_vec()}, {1'b1, 5'b0, 6'b100011});
      #1 rst = 1'b0;
      #1 chk("async_rst", {bus.rx_out, 5'b0, drv_vec()}, {1'b0, 5'b0, 6'b010001});
      #2 rst = 1'b1;
      step();
      chk("post_rst_tx", {6'b0, drv_vec()}, {6'b0, 6'b100011});
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aib_pad_txrx_ctrl.md
Name: aib_pad_txrx_ctrl

Overview:
Synthesizable digital core of one AIB I/O pad slice.
- Registers transmit data and generates the strong pull-up/pull-down enables for the Gen1 and Gen2 drivers, plus the weak-pull enables. Power-good, the pad-low strap and calibration masks gate these enables.
- Resolves the enables into a pad drive value and output enable, and samples the received pad value.
- Sits between the adapter datapath and the analog driver/receiver macro.

Parameters:
RST_VAL, 1'b0, value loaded into both sample flops on reset and when their path is disabled.

Ports:
clk  in  1  sampling clock for TX and RX flops (rising edge)
rst  in  1  asynchronous active-low reset
tx_data  in  1  synchronous transmit data
tx_en  in  1  transmit enable
tx_async  in  1  asynchronous transmit data
tx_async_en  in  1  select tx_async instead of the registered data
gen1mode_en  in  1  1 = Gen1 drivers, 0 = Gen2 drivers
tx_compen_p  in  1  pull-up calibration mask
tx_compen_n  in  1  pull-down calibration mask
pwrgood  in  1  core power good
pwrgood_io  in  1  IO power good
rst_padlow_strap  in  1  force pad low
wkpu_en  in  1  weak pull-up request
wkpd_en  in  1  weak pull-down request
rx_en  in  1  receive enable
rx_async_en  in  1  asynchronous receive bypass enable
pad_in  in  1  pad value from receiver
pu_gen1, pd_gen1, pu_gen2, pd_gen2  out  1 each  strong driver enables
wkpu, wkpd  out  1 each  weak pull enables
pad_oe  out  1  pad actively driven (strong or weak)
pad_strong  out  1  a strong driver is on
pad_out  out  1  resolved pad drive value
pad_contention  out  1  strong pull-up and pull-down both on
rx_out  out  1  registered receive data
rx_async  out  1  rx_async_en ? pad_in : 0

Behaviour:
TX register (tx_q):
- rst=0 → tx_q=RST_VAL, asynchronously.
- Each rising clk edge: tx_q <= tx_en ? tx_data : RST_VAL.
- Latency is 1 clk.

Data select: d = tx_async_en ? tx_async : tx_q. This is combinational, so tx_async has 0-cycle latency.

Enable logic (combinational, in priority order):
1. pwrgood=0 or pwrgood_io=0: all six enables = 0.
2. rst_padlow_strap=1:
   - pd of the selected generation = 1, ignoring compen_n.
   - All pull-ups = 0; weak pulls = 0.
3. tx_en=1 or tx_async_en=1:
   - pu_sel = d & tx_compen_p; pd_sel = ~d & tx_compen_n.
   - Routed to the gen1 pair if gen1mode_en=1, else to the gen2 pair.
   - The unselected pair = 0; weak pulls = 0.
4. Otherwise: wkpu = wkpu_en & ~wkpd_en; wkpd = wkpd_en & ~wkpu_en. Both requested → neither is on.

Pad resolution (combinational):
- spu = pu_gen1 | pu_gen2; spd = pd_gen1 | pd_gen2.
- pad_strong = spu | spd; pad_oe = pad_strong | wkpu | wkpd.
- pad_out = spu ? 1 : spd ? 0 : wkpu ? 1 : 0.
- pad_contention = spu & spd. This is unreachable by construction; the bench asserts it is never 1.

RX register (rx_q):
- rst=0 → rx_q=RST_VAL, asynchronously.
- Each rising clk edge: rx_q <= rx_en ? pad_in : RST_VAL.
- rx_out = rx_q; latency is 1 clk.

Reset values:
- tx_q = rx_out = 0.
- Enables follow the combinational rules with d=0 (or tx_async). With tx_en=1 and power good, the selected pd is on right after reset.

Mid-operation changes:
- Deasserting power takes effect immediately and overrides everything, including the strap.
- Toggling gen1mode_en switches pairs in the same cycle, with no overlap.
- Deasserting tx_en clears tx_q on the next edge; the enables drop immediately unless tx_async_en=1.

Decomposition:
- Shared package aib_pad_pkg:
  - struct pad_drv_t {pu_gen1, pd_gen1, pu_gen2, pd_gen2, wkpu, wkpd}.
  - Constant PAD_DRV_OFF.
- Sub-module txrx_sample_ff: single-bit flop with async active-low reset, an enable-to-clear input and RST_VAL. It is instantiated for TX and for RX.
- Enable logic and pad resolution are combinational blocks in the top level.

Test Plan:
- Reset, then power good, tx_en=1, gen1mode_en=1, both compen=1, tx_data=1 at edge N → pu_gen1=1, pad_out=1, pad_oe=1 after edge N; tx_data=0 → pd_gen1=1, pad_out=0; gen2 pair stays 0.
- gen1mode_en=0, tx_async_en=1, toggle tx_async 0/1 with no clk → pu_gen2/pd_gen2 follow in the same cycle; gen1 pair = 0.
- rst_padlow_strap=1 with d=1 → pd of selected gen=1, pu=0, pad_out=0; then pwrgood=0 → all enables 0, pad_oe=0.
- tx_en=0, tx_async_en=0, wkpu_en=1 → wkpu=1, pad_strong=0, pad_out=1; wkpd_en=1 also → wkpu=wkpd=0, pad_oe=0.
- rx_en=1, pad_in pattern 1,0,1 → rx_out is the same pattern delayed 1 clk; rx_async_en=1 → rx_async=pad_in immediately; rx_en=0 → rx_out=0 next edge.
- Async rst pulse mid-stream → rx_out and tx_q are 0 immediately, without a clk edge; pad_contention stays 0 throughout all tests.
